// File: rtl/capture_timer_mc_if.sv
// Bus bundle for the multi-channel capture timer: raw trigger levels,
// per-channel mode/clear controls and the registered timer/capture outputs.
interface capture_timer_mc_if #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 4
);
  logic                     start_i;
  logic                     rst_capture_i;
  logic [NUM_CH-1:0]        capture_i;
  logic [NUM_CH-1:0]        mode_cont_i;
  logic [NUM_CH-1:0]        clear_i;
  logic [CNT_W-1:0]         counter_o;
  logic                     running_o;
  logic                     wrap_o;
  logic [NUM_CH*CNT_W-1:0]  captured_o;
  logic [NUM_CH-1:0]        valid_o;
  logic [NUM_CH-1:0]        overrun_o;

  // Side that drives triggers and controls, observes the timer
  modport master (
    output start_i, rst_capture_i, capture_i, mode_cont_i, clear_i,
    input  counter_o, running_o, wrap_o, captured_o, valid_o, overrun_o
  );

  // Timer block side
  modport slave (
    input  start_i, rst_capture_i, capture_i, mode_cont_i, clear_i,
    output counter_o, running_o, wrap_o, captured_o, valid_o, overrun_o
  );
endinterface

// File: rtl/capture_timer_mc.sv
// Multi-channel capture timer: one shared free-running timebase, NUM_CH
// single-shot/continuous capture channels, synchronised edge-detected triggers.
module capture_timer_mc #(
  parameter int CNT_W       = 32,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_an_i,
  capture_timer_mc_if.slave bus
);

  // Raw lines: bit 0 start, bit 1 rst_capture, bits [NUM_CH+1:2] capture.
  localparam int NUM_RAW = NUM_CH + 2;

  typedef enum logic { G_IDLE, G_RUN }    gstate_t;
  typedef enum logic { CH_ARMED, CH_DONE } chstate_t;

  logic [NUM_RAW-1:0] r_sync [SYNC_STAGES];
  logic [NUM_RAW-1:0] r_prev;
  logic [NUM_RAW-1:0] w_raw;
  logic [NUM_RAW-1:0] w_pulse;
  logic               w_start_p;
  logic               w_rstcap_p;
  logic [NUM_CH-1:0]  w_cap_p;

  gstate_t            r_gstate, w_gstate_nxt;
  logic [CNT_W-1:0]   r_counter, w_counter_nxt;
  logic               r_wrap, w_wrap_nxt;

  chstate_t           r_ch_state [NUM_CH];
  chstate_t           w_ch_state_nxt [NUM_CH];
  logic [CNT_W-1:0]   r_cap [NUM_CH];
  logic [CNT_W-1:0]   w_cap_nxt [NUM_CH];
  logic [NUM_CH-1:0]  r_valid, w_valid_nxt;
  logic [NUM_CH-1:0]  r_ovr, w_ovr_nxt;

  assign w_raw = {bus.capture_i, bus.rst_capture_i, bus.start_i};

  // Synchronise every raw line, plus one extra flop holding the previous value
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_pulse    = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_start_p  = w_pulse[0];
  assign w_rstcap_p = w_pulse[1];
  assign w_cap_p    = w_pulse[NUM_RAW-1:2];

  // Global IDLE/RUN next state, timebase and wrap flag; rst_capture beats start
  // NOTE: every output of a combinational block gets a default first, so no latches.
  always_comb begin
    w_gstate_nxt  = r_gstate;
    w_counter_nxt = r_counter;
    w_wrap_nxt    = r_wrap;
    if (w_rstcap_p) begin
      w_gstate_nxt = G_IDLE;
      w_wrap_nxt   = 1'b0;
    end else if (w_start_p) begin
      w_gstate_nxt  = G_RUN;
      w_counter_nxt = '0;
      w_wrap_nxt    = 1'b0;
    end else if (r_gstate == G_RUN) begin
      w_counter_nxt = r_counter + 1'b1;
      if (&r_counter) w_wrap_nxt = 1'b1;
    end
  end

  // Global state, timebase and wrap registers
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      r_gstate  <= G_IDLE;
      r_counter <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_gstate  <= w_gstate_nxt;
      r_counter <= w_counter_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

  // Per-channel ARMED/DONE next state and flags; a same-cycle clear rearms
  // the channel first so a coincident capture lands on a clean channel
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_ch_state_nxt[ch] = r_ch_state[ch];
      w_cap_nxt[ch]      = r_cap[ch];
      w_valid_nxt[ch]    = r_valid[ch];
      w_ovr_nxt[ch]      = r_ovr[ch];
      if (w_rstcap_p) begin
        w_ch_state_nxt[ch] = CH_ARMED;
        w_cap_nxt[ch]      = '0;
        w_valid_nxt[ch]    = 1'b0;
        w_ovr_nxt[ch]      = 1'b0;
      end else if (w_start_p) begin
        w_ch_state_nxt[ch] = CH_ARMED;
        w_valid_nxt[ch]    = 1'b0;
        w_ovr_nxt[ch]      = 1'b0;
      end else begin
        if (bus.clear_i[ch]) begin
          w_ch_state_nxt[ch] = CH_ARMED;
          w_valid_nxt[ch]    = 1'b0;
          w_ovr_nxt[ch]      = 1'b0;
        end
        if (w_cap_p[ch] && (r_gstate == G_RUN)) begin
          if (w_ch_state_nxt[ch] == CH_ARMED) begin
            w_cap_nxt[ch] = r_counter;
            if (w_valid_nxt[ch]) w_ovr_nxt[ch] = 1'b1;
            w_valid_nxt[ch] = 1'b1;
            if (!bus.mode_cont_i[ch]) w_ch_state_nxt[ch] = CH_DONE;
          end else begin
            w_ovr_nxt[ch] = 1'b1;
          end
        end
      end
    end
  end

  // Per-channel state, capture data and flag registers
  // NOTE: capture registers are plain flops with a defined reset value, not RAM.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_ch_state[ch] <= CH_ARMED;
        r_cap[ch]      <= '0;
      end
      r_valid <= '0;
      r_ovr   <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_ch_state[ch] <= w_ch_state_nxt[ch];
        r_cap[ch]      <= w_cap_nxt[ch];
      end
      r_valid <= w_valid_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign bus.captured_o[g*CNT_W +: CNT_W] = r_cap[g];
  end

  assign bus.counter_o = r_counter;
  assign bus.running_o = (r_gstate == G_RUN);
  assign bus.wrap_o    = r_wrap;
  assign bus.valid_o   = r_valid;
  assign bus.overrun_o = r_ovr;

endmodule

// File: tb/tb_capture_timer_mc.sv
// Directed bench for capture_timer_mc (CNT_W=4, NUM_CH=4, SYNC_STAGES=2).
// Stimulus pushes expected snapshots and capture results into queues; a
// monitor pops snapshots on the falling edge and pops capture results
// whenever a valid_o bit rises.
module tb_capture_timer_mc;
  localparam int CNT_W       = 4;
  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;

  logic clk_i = 1'b0;
  logic rst_an_i;

  always #5 clk_i = ~clk_i;

  capture_timer_mc_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) bus ();

  capture_timer_mc #(
    .CNT_W(CNT_W), .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_i    (clk_i),
    .rst_an_i (rst_an_i),
    .bus      (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  cnt;
    logic        run;
    logic        wrap;
    logic [15:0] cap;
    logic [3:0]  vld;
    logic [3:0]  ovr;
  } snap_t;

  typedef struct {
    int         ch;
    logic [3:0] data;
  } capexp_t;

  snap_t   snap_q[$];
  capexp_t cap_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  logic [3:0] mon_prev_v = '0;
  snap_t   mon_s;
  capexp_t mon_c;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic snap(input string name, input logic [3:0] cnt, input logic run,
                      input logic wrap, input logic [15:0] cap,
                      input logic [3:0] vld, input logic [3:0] ovr);
    snap_t s;
    s.name = name; s.cnt = cnt; s.run = run; s.wrap = wrap;
    s.cap = cap; s.vld = vld; s.ovr = ovr;
    snap_q.push_back(s);
  endtask

  task automatic push_cap(input int ch, input logic [3:0] data);
    capexp_t c;
    c.ch = ch; c.data = data;
    cap_q.push_back(c);
  endtask

  // Monitor: compare queued snapshots, and match each valid_o rise to an expected capture
  initial begin
    forever begin
      @(negedge clk_i);
      while (snap_q.size() > 0) begin
        mon_s = snap_q.pop_front();
        check({mon_s.name, ".counter"},  32'(bus.counter_o),  32'(mon_s.cnt));
        check({mon_s.name, ".running"},  32'(bus.running_o),  32'(mon_s.run));
        check({mon_s.name, ".wrap"},     32'(bus.wrap_o),     32'(mon_s.wrap));
        check({mon_s.name, ".captured"}, 32'(bus.captured_o), 32'(mon_s.cap));
        check({mon_s.name, ".valid"},    32'(bus.valid_o),    32'(mon_s.vld));
        check({mon_s.name, ".overrun"},  32'(bus.overrun_o),  32'(mon_s.ovr));
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (bus.valid_o[ch] && !mon_prev_v[ch]) begin
          if (cap_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid_rise: ch %0d data %0h, no capture expected", ch,
                     bus.captured_o[ch*CNT_W +: CNT_W]);
          end else begin
            mon_c = cap_q.pop_front();
            check("valid_rise.channel", 32'(ch), 32'(mon_c.ch));
            check("valid_rise.data", 32'(bus.captured_o[ch*CNT_W +: CNT_W]), 32'(mon_c.data));
          end
        end
      end
      mon_prev_v = bus.valid_o;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus; comments give edges relative to the last raw start edge
  initial begin
    rst_an_i          = 1'b1;
    bus.start_i       = 1'b0;
    bus.rst_capture_i = 1'b0;
    bus.capture_i     = '0;
    bus.mode_cont_i   = '0;
    bus.clear_i       = '0;
    #3 rst_an_i = 1'b0;
    step(2);
    snap("reset", 4'd0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
    rst_an_i = 1'b1;
    step(3);
    snap("idle_after_reset", 4'd0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);

    // Basic single-shot on ch0: edge 10 cycles after start captures 9
    bus.start_i = 1'b1;                                 // P0
    step(10); bus.capture_i[0] = 1'b1; push_cap(0, 4'd9); // P10
    step(2);  bus.capture_i[0] = 1'b0;                  // P12
    step(1);  bus.capture_i[0] = 1'b1;                  // P13, lands in DONE
    step(1);  bus.capture_i[0] = 1'b0;                  // P14
    snap("single_first", 4'd11, 1'b1, 1'b0, 16'h0009, 4'h1, 4'h0);
    step(3);                                            // P17
    snap("single_done_overrun", 4'd14, 1'b1, 1'b0, 16'h0009, 4'h1, 4'h1);

    // Continuous ch1: edges at 5 and 12 cycles capture 4 then 11 with overrun
    bus.start_i = 1'b0; bus.mode_cont_i = 4'b0010;
    step(1); bus.start_i = 1'b1;                        // P0
    step(5); bus.capture_i[1] = 1'b1; push_cap(1, 4'd4);  // P5
    step(2); bus.capture_i[1] = 1'b0;                   // P7
    step(5); bus.capture_i[1] = 1'b1;                   // P12
    step(2); bus.capture_i[1] = 1'b0;                   // P14
    step(2);                                            // P16
    snap("cont_overrun", 4'd13, 1'b1, 1'b0, 16'h00B9, 4'h2, 4'h2);
    bus.clear_i = 4'b0010;
    step(1); bus.clear_i = '0;                          // P17
    snap("cont_clear", 4'd14, 1'b1, 1'b0, 16'h00B9, 4'h0, 4'h0);

    // ch2: capture, overrun in DONE, then capture together with clear
    bus.start_i = 1'b0; bus.mode_cont_i = '0;
    step(1); bus.start_i = 1'b1;                        // P0
    step(3); bus.capture_i[2] = 1'b1; push_cap(2, 4'd2);  // P3
    step(2); bus.capture_i[2] = 1'b0;                   // P5
    step(1); bus.capture_i[2] = 1'b1;                   // P6
    step(2); bus.capture_i[2] = 1'b0;                   // P8
    step(1); bus.capture_i[2] = 1'b1;                   // P9
    step(1);                                            // P10
    snap("ch2_done_overrun", 4'd7, 1'b1, 1'b0, 16'h02B9, 4'h4, 4'h4);
    step(1); bus.capture_i[2] = 1'b0; bus.clear_i = 4'b0100; // P11
    step(1); bus.clear_i = '0;                          // P12
    snap("ch2_capture_and_clear", 4'd9, 1'b1, 1'b0, 16'h08B9, 4'h4, 4'h0);

    // Start and ch3 capture edges together: capture dropped
    bus.start_i = 1'b0;
    step(1); bus.start_i = 1'b1; bus.capture_i[3] = 1'b1; // E0
    step(1); bus.capture_i[3] = 1'b0;                   // E1
    step(3);                                            // E4
    snap("start_with_capture", 4'd1, 1'b1, 1'b0, 16'h08B9, 4'h0, 4'h0);

    // Wrap of the 4-bit timebase, then a restart clears it
    step(14);                                           // E18
    snap("before_wrap", 4'd15, 1'b1, 1'b0, 16'h08B9, 4'h0, 4'h0);
    step(1);                                            // E19
    snap("at_wrap", 4'd0, 1'b1, 1'b1, 16'h08B9, 4'h0, 4'h0);
    step(1); bus.start_i = 1'b0;                        // E20
    snap("after_wrap", 4'd1, 1'b1, 1'b1, 16'h08B9, 4'h0, 4'h0);
    step(1); bus.start_i = 1'b1;                        // E21 = F0
    step(2);                                            // E23
    snap("wrap_sticky", 4'd4, 1'b1, 1'b1, 16'h08B9, 4'h0, 4'h0);
    step(1);                                            // F3
    snap("restart_clears_wrap", 4'd0, 1'b1, 1'b0, 16'h08B9, 4'h0, 4'h0);

    // rst_capture while running, then capture edges in IDLE are ignored
    bus.capture_i[1] = 1'b1; push_cap(1, 4'd2);         // F3
    step(2); bus.capture_i[1] = 1'b0;                   // F5
    step(1); bus.rst_capture_i = 1'b1;                  // F6
    snap("before_rst_capture", 4'd3, 1'b1, 1'b0, 16'h0829, 4'h2, 4'h0);
    step(3);                                            // F9
    snap("rst_capture", 4'd5, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
    step(2); bus.capture_i[0] = 1'b1; bus.capture_i[2] = 1'b1; // F11
    step(4);                                            // F15
    snap("idle_capture_ignored", 4'd5, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
    bus.capture_i = '0; bus.start_i = 1'b0; bus.rst_capture_i = 1'b0;

    // Async reset with ch0 valid; held-high capture must toggle to count again
    step(1); bus.start_i = 1'b1;                        // G0
    step(4); bus.capture_i[0] = 1'b1; push_cap(0, 4'd3);  // G4
    step(4);                                            // G8
    snap("before_async_reset", 4'd5, 1'b1, 1'b0, 16'h0003, 4'h1, 4'h0);
    bus.start_i = 1'b0;
    step(1); rst_an_i = 1'b0; #1;                       // G9
    snap("async_reset", 4'd0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
    step(1); rst_an_i = 1'b1;                           // G10
    step(1);                                            // G11
    snap("after_release", 4'd0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
    step(2); bus.start_i = 1'b1;                        // G13 = H0
    step(5);                                            // H5
    snap("held_capture_no_effect", 4'd2, 1'b1, 1'b0, 16'h0000, 4'h0, 4'h0);
    bus.capture_i[0] = 1'b0;
    step(1); bus.capture_i[0] = 1'b1; push_cap(0, 4'd5);  // H6
    step(4);                                            // H10
    snap("toggled_capture", 4'd7, 1'b1, 1'b0, 16'h0005, 4'h1, 4'h0);

    step(3);
    check("pending_captures", 32'(cap_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
